// File: rtl/sudoku_group_checker_if.sv
// Controller handshake plus board-memory read bus for the Sudoku group checker.
// slave: the checker itself; master: controller and board store side.
// Result flags travel with the handshake so one bundle connects both sides.
interface sudoku_group_checker_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 7
);
  logic              start;
  logic [1:0]        group_sel;
  logic [3:0]        group_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic              group_ok;
  logic [DATA_W-1:0] dup_value;
  logic [3:0]        empty_cnt;
  logic              range_err;
  logic              bad_req;

  modport master (
    output start, group_sel, group_idx, rd_data,
    input  rd_en, rd_addr, busy, done, group_ok, dup_value, empty_cnt, range_err, bad_req
  );

  modport slave (
    input  start, group_sel, group_idx, rd_data,
    output rd_en, rd_addr, busy, done, group_ok, dup_value, empty_cnt, range_err, bad_req
  );
endinterface

// File: rtl/sudoku_group_checker.sv
// Scans one Sudoku row/column/box of the board store for duplicate and illegal digits.
// Latency: done 11 cycles after an accepted legal start, 1 cycle after an illegal one.
// No backpressure: start is dropped while busy or in DONE; no request queueing.
module sudoku_group_checker #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 7,
  parameter int N_CELLS = 9
) (
  input logic                   clka,
  input logic                   restart,
  sudoku_group_checker_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] LAST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [3:0] LAST_K = 4'(N_CELLS - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        k_q;
  logic [1:0]        sel_q;
  logic [3:0]        idx_q;
  logic [8:0]        seen_q, seen_d;
  logic [DATA_W-1:0] dup_q, dup_d;
  logic [3:0]        empty_q, empty_d;
  logic              range_q, range_d;
  logic              bad_q;
  logic              ok_q;
  logic              req_bad;
  logic              consume;
  logic [3:0]        cell_bit;

  // Board address of cell k of the selected group (addr = row*9 + col).
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [1:0] sel,
                                                  input logic [3:0] idx,
                                                  input logic [3:0] k);
    int r;
    int c;
    case (sel)
      2'd0:    begin r = int'(idx); c = int'(k); end
      2'd1:    begin r = int'(k);   c = int'(idx); end
      default: begin
        r = (int'(idx) / 3) * 3 + int'(k) / 3;
        c = (int'(idx) % 3) * 3 + int'(k) % 3;
      end
    endcase
    return ADDR_W'(r * 9 + c);
  endfunction

  assign req_bad  = (bus.group_sel == 2'd3) || (bus.group_idx > 4'd8);
  // Read data lags the address by one cycle, so the first READ cycle has nothing to consume.
  assign consume  = ((state_q == READ) && (k_q != 4'd0)) || (state_q == LAST);
  assign cell_bit = 4'(bus.rd_data - DATA_W'(1));

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = req_bad ? DONE : READ;
      READ:    if (k_q == LAST_K) state_d = LAST;
      LAST:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Fold the returning cell value into the seen-mask, duplicate, empty and range trackers.
  always_comb begin
    seen_d  = seen_q;
    dup_d   = dup_q;
    empty_d = empty_q;
    range_d = range_q;
    if (consume) begin
      if (bus.rd_data == '0) begin
        empty_d = empty_q + 4'd1;
      end else if (bus.rd_data <= DATA_W'(9)) begin
        if (seen_q[cell_bit] && (dup_q == '0)) dup_d = bus.rd_data;
        seen_d[cell_bit] = 1'b1;
      end else begin
        range_d = 1'b1;
      end
    end
  end

  // Sequencer state, request latch, cell index and result registers.
  always_ff @(posedge clka) begin
    if (restart) begin
      state_q <= IDLE;
      k_q     <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      seen_q  <= '0;
      dup_q   <= '0;
      empty_q <= '0;
      range_q <= 1'b0;
      bad_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      dup_q   <= dup_d;
      empty_q <= empty_d;
      range_q <= range_d;
      if ((state_q == IDLE) && bus.start) begin
        sel_q   <= bus.group_sel;
        idx_q   <= bus.group_idx;
        k_q     <= '0;
        seen_q  <= '0;
        dup_q   <= '0;
        empty_q <= '0;
        range_q <= 1'b0;
        bad_q   <= req_bad;
        ok_q    <= 1'b0;
      end
      if ((state_q == READ) && (k_q != LAST_K)) k_q <= k_q + 4'd1;
      // Use the _d values so the cell-8 result consumed on this edge is included.
      if (state_q == LAST) ok_q <= (dup_d == '0) && !range_d && !bad_q;
    end
  end

  assign bus.rd_en     = (state_q == READ);
  assign bus.rd_addr   = (state_q == READ) ? cell_addr(sel_q, idx_q, k_q) : '0;
  assign bus.busy      = (state_q == READ) || (state_q == LAST);
  assign bus.done      = (state_q == DONE);
  assign bus.group_ok  = ok_q;
  assign bus.dup_value = dup_q;
  assign bus.empty_cnt = empty_q;
  assign bus.range_err = range_q;
  assign bus.bad_req   = bad_q;

endmodule

// File: tb/tb_sudoku_group_checker.sv
// Directed bench for sudoku_group_checker: board memory model, scoreboard of expected results.
// Checks latency, read address sequence, result flags, ignored start and mid-scan restart.
module tb_sudoku_group_checker;

  typedef struct {
    int ok;
    int dup;
    int empty;
    int range_e;
    int bad;
  } res_t;

  typedef int vals_t[9];

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [3:0] mem [81];
  res_t sb[$];

  sudoku_group_checker_if bus ();

  sudoku_group_checker dut (
    .clka    (clk),
    .restart (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read board store.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int sel, input int idx, input int k);
    if (sel == 0) return idx * 9 + k;
    if (sel == 1) return k * 9 + idx;
    return ((idx / 3) * 3 + k / 3) * 9 + (idx % 3) * 3 + k % 3;
  endfunction

  task automatic set_group(input int sel, input int idx, input vals_t v);
    for (int k = 0; k < 9; k++) mem[addr_of(sel, idx, k)] = 4'(v[k]);
  endtask

  function automatic res_t model(input int sel, input int idx);
    res_t r;
    logic [15:0] seen;
    int v;
    r = '{ok: 0, dup: 0, empty: 0, range_e: 0, bad: 0};
    seen = '0;
    if (sel == 3 || idx > 8) begin
      r.bad = 1;
      return r;
    end
    for (int k = 0; k < 9; k++) begin
      v = int'(mem[addr_of(sel, idx, k)]);
      if (v == 0) r.empty++;
      else if (v <= 9) begin
        if (seen[v] && r.dup == 0) r.dup = v;
        seen[v] = 1'b1;
      end else r.range_e = 1;
    end
    r.ok = (r.dup == 0 && r.range_e == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_done"},  int'(bus.done), 0);
    check({tag, "_busy"},  int'(bus.busy), 0);
    check({tag, "_rd_en"}, int'(bus.rd_en), 0);
    check({tag, "_addr"},  int'(bus.rd_addr), 0);
    check({tag, "_ok"},    int'(bus.group_ok), 0);
    check({tag, "_dup"},   int'(bus.dup_value), 0);
    check({tag, "_empty"}, int'(bus.empty_cnt), 0);
    check({tag, "_range"}, int'(bus.range_err), 0);
    check({tag, "_bad"},   int'(bus.bad_req), 0);
  endtask

  // Issue one request; start2_at re-pulses start at that cycle, rst_at pulses restart.
  task automatic run_req(input string tag, input int sel, input int idx,
                         input int start2_at, input int rst_at);
    int   exp_addr[$];
    int   got_addr[$];
    int   done_at;
    int   done_cnt;
    bit   legal;
    res_t e;
    done_at  = 0;
    done_cnt = 0;
    legal    = !(sel == 3 || idx > 8);
    if (legal) for (int k = 0; k < 9; k++) exp_addr.push_back(addr_of(sel, idx, k));
    if (rst_at == 0) sb.push_back(model(sel, idx));
    bus.group_sel = 2'(sel);
    bus.group_idx = 4'(idx);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.rd_en) got_addr.push_back(int'(bus.rd_addr));
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = n;
          check({tag, "_sb_nonempty"}, (sb.size() > 0) ? 1 : 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_group_ok"},  int'(bus.group_ok),  e.ok);
            check({tag, "_dup_value"}, int'(bus.dup_value), e.dup);
            check({tag, "_empty_cnt"}, int'(bus.empty_cnt), e.empty);
            check({tag, "_range_err"}, int'(bus.range_err), e.range_e);
            check({tag, "_bad_req"},   int'(bus.bad_req),   e.bad);
          end
          check({tag, "_busy_at_done"}, int'(bus.busy), 0);
          check({tag, "_addr_at_done"}, int'(bus.rd_addr), 0);
        end
      end
      if (n == 5 && legal && rst_at == 0) check({tag, "_busy_mid"}, int'(bus.busy), 1);
      if (rst_at != 0 && n == rst_at + 1) begin
        check_zero({tag, "_after_restart"});
        rst = 1'b0;
      end
      bus.start = (start2_at != 0 && n == start2_at);
      if (rst_at != 0 && n == rst_at) rst = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    if (rst_at == 0) begin
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_done_cycle"}, done_at, legal ? 11 : 1);
      check({tag, "_rd_en_cycles"}, got_addr.size(), exp_addr.size());
      for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++)
        check($sformatf("%s_addr%0d", tag, k), got_addr[k], exp_addr[k]);
    end else begin
      check({tag, "_no_done"}, done_cnt, 0);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.group_sel = '0;
    bus.group_idx = '0;
    bus.rd_data   = '0;
    for (int a = 0; a < 81; a++) mem[a] = 4'd0;

    @(posedge clk); @(posedge clk); #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    set_group(0, 0, '{5, 3, 0, 0, 7, 0, 0, 0, 0});
    run_req("row0", 0, 0, 0, 0);

    set_group(1, 4, '{1, 2, 3, 4, 5, 6, 7, 2, 9});
    run_req("col4", 1, 4, 0, 0);

    set_group(2, 8, '{1, 2, 3, 4, 5, 6, 7, 8, 9});
    run_req("box8", 2, 8, 0, 0);

    set_group(0, 3, '{4, 12, 1, 4, 0, 2, 3, 5, 6});
    run_req("row3", 0, 3, 0, 0);

    run_req("sel3", 3, 0, 0, 0);
    run_req("idx9", 0, 9, 0, 0);

    // First-found duplicate wins; later repeat of 5 must not overwrite 3.
    set_group(1, 0, '{3, 3, 5, 5, 0, 15, 1, 2, 9});
    run_req("col0", 1, 0, 0, 0);

    // Duplicate only at the final cell, with a second start mid-scan.
    set_group(0, 1, '{1, 2, 3, 4, 5, 6, 7, 8, 8});
    run_req("row1_restart_ignored", 0, 1, 4, 0);

    set_group(1, 2, '{0, 0, 0, 9, 9, 0, 0, 0, 0});
    run_req("col2_abort", 1, 2, 0, 6);

    set_group(2, 4, '{9, 8, 7, 0, 5, 4, 0, 2, 1});
    run_req("box4_fresh", 2, 4, 0, 0);

    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sudoku_group_checker.md
Name: sudoku_group_checker

Overview:
- Datapath responder for the main controller's start/done handshake.
- On a one-cycle `start` pulse, scans one Sudoku group (row, column or 3x3 box) of the 81-cell board store.
- Checks the group for duplicate and out-of-range digits, then returns a one-cycle `done` pulse with the result flags held stable.
- Sits between the controller and the synchronous-read board memory.

Parameters:
- DATA_W, 4, cell value width (0 = empty, 1..9 = digit, 10..15 = illegal)
- ADDR_W, 7, board address width (cells 0..80, addr = row*9 + col)
- N_CELLS, 9, cells per group

Ports:
- clka  input  1  single system clock; all logic on rising edge
- restart  input  1  synchronous, active-high reset
- start  input  1  one-cycle request pulse from controller
- group_sel  input  2  group type: 0 row, 1 column, 2 box, 3 reserved
- group_idx  input  4  group number 0..8 (box numbering row-major)
- rd_data  input  DATA_W  board memory read data, valid the cycle after rd_en
- rd_en  output  1  board memory read enable
- rd_addr  output  ADDR_W  board memory read address
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle completion pulse
- group_ok  output  1  1 = no duplicate, no illegal value, legal request
- dup_value  output  DATA_W  first digit found repeated in scan order, 0 if none
- empty_cnt  output  4  number of zero cells in the group (0..9)
- range_err  output  1  a cell held a value 10..15
- bad_req  output  1  group_sel = 3 or group_idx > 8

Behaviour:
- Reset (restart = 1 at a clka edge) clears all outputs to 0 and the internal seen-mask, index and counters, and forces state IDLE.
  - This applies mid-scan: no done is issued for an aborted request.
- States: IDLE, READ, LAST, DONE.
- IDLE:
  - On start = 1, latch group_sel/group_idx and clear seen-mask, empty_cnt, dup_value, range_err and bad_req.
  - Legal request: go to READ, k = 0.
  - Illegal request: set bad_req = 1 and go directly to DONE.
- READ, 9 cycles, k = 0..8:
  - rd_en = 1, rd_addr = address of cell k.
    - Row r: r*9 + k.
    - Column c: k*9 + c.
    - Box b: ((b/3)*3 + k/3)*9 + (b%3)*3 + k%3.
  - From the second READ cycle on, consume rd_data for cell k-1.
  - After k = 8, go to LAST.
- LAST: rd_en = 0, consume rd_data for cell 8, go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, go to IDLE.
  - Result outputs are held until the next accepted start.
- Consume rules, per cell value v:
  - v = 0: empty_cnt += 1.
  - v in 1..9: if seen[v] is already set and dup_value == 0, set dup_value = v; then set seen[v].
  - v >= 10: range_err = 1; seen-mask unchanged.
- group_ok, registered at the LAST->DONE transition: (dup_value == 0) and not range_err and not bad_req. On the bad_req path, group_ok = 0.
- Latency:
  - Legal request: start sampled at edge T, done high in cycle T+11.
  - Illegal request: done in cycle T+1.
- busy = 1 during READ and LAST. start is ignored while busy or while in DONE; no queueing.
- Outputs change only on clka edges. rd_addr returns to 0 when rd_en = 0.

Test Plan:
- Reset, then row 0 = 5,3,0,0,7,0,0,0,0 -> done at T+11, group_ok = 1, empty_cnt = 6, dup_value = 0, 9 rd_en cycles with addresses 0..8.
- Column 4 with cells 1,2,3,4,5,6,7,2,9 -> rd_addr = 4,13,22,...,76; group_ok = 0, dup_value = 2, empty_cnt = 0.
- Box 8 full legal digits 1..9 -> addresses 60,61,62,69,70,71,78,79,80; group_ok = 1, empty_cnt = 0.
- Row 3 containing values 12 and a repeated 4 -> range_err = 1, dup_value = 4, group_ok = 0.
- start with group_sel = 3, then separately group_idx = 9 -> done at T+1, bad_req = 1, group_ok = 0, no rd_en.
- Second start pulse at T+4 during a scan -> ignored, single done at T+11.
- restart asserted at T+6 -> all outputs 0 next cycle, no done; a fresh start then completes normally.
